// File: rtl/restador_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The requester drives start/A/B. The subtractor returns busy/done and the held result.
interface restador_serial_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] C;
  logic             borrow;
  logic             zero;

  modport master (
    output start, A, B,
    input  busy, done, C, borrow, zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, C, borrow, zero
  );
endinterface

// File: rtl/restador_serial.sv
// Bit-serial unsigned subtractor C = A - B (mod 2^WIDTH) with a start/done handshake.
// A single full-subtractor cell processes one bit per clock, starting at the LSB.
// The result, final borrow and zero flag are registered on the edge that enters DONE.
// They are then held until the next operation completes.
module restador_serial #(
  parameter int WIDTH = 12
) (
  input logic               clk,
  input logic               rst,
  restador_serial_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_rr;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_c;
  logic             r_borrow;
  logic             r_zero;

  logic             w_diff;
  logic             w_br_next;
  logic [WIDTH-1:0] w_rr_next;
  logic             w_last;

  // Full-subtractor cell on the current LSBs, plus the next result-register value.
  // The final bit is folded into the registered outputs on the same edge.
  assign w_diff    = r_ra[0] ^ r_rb[0] ^ r_br;
  assign w_br_next = (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_br);
  assign w_rr_next = {w_diff, r_rr[WIDTH-1:1]};
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  // Control FSM and serial datapath: accept, shift one bit per clock, publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ra     <= '0;
      r_rb     <= '0;
      r_rr     <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_c      <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_ra    <= bus.A;
            r_rb    <= bus.B;
            r_rr    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // Zeros shift into the operand MSBs so that no stale bits are recirculated.
          r_ra  <= {1'b0, r_ra[WIDTH-1:1]};
          r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
          r_rr  <= w_rr_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_c      <= w_rr_next;
            r_borrow <= w_br_next;
            r_zero   <= (w_rr_next == '0);
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          // A start in the DONE cycle is accepted directly, which gives back-to-back operation.
          if (bus.start) begin
            r_ra    <= bus.A;
            r_rb    <= bus.B;
            r_rr    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.C      = r_c;
  assign bus.borrow = r_borrow;
  assign bus.zero   = r_zero;
endmodule
